// File: rtl/inst_mem_loader_if.sv
// Byte-stream ingress and instruction-RAM write bus shared by the boot loader and its environment.
// The master drives the byte stream; the slave (the loader) drives the write bus.
interface inst_mem_loader_if #(
    parameter int W = 32
);
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic         is_write;
    logic [W-1:0] im_addr;
    logic [W-1:0] im_inst;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  is_write,
        input  im_addr,
        input  im_inst
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output is_write,
        output im_addr,
        output im_inst
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Boot loader: parses [len_lo, len_hi, N*4 LE instruction bytes, xor checksum] into instruction RAM writes.
// Write issues 1 cycle after a word's 4th byte; rx_ready depends on state only, so 1 byte/cycle never stalls.
module inst_mem_loader #(
    parameter int           W         = 32,
    parameter logic [W-1:0] BASE_ADDR = '0,
    parameter int           MAX_WORDS = 2057
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    inst_mem_loader_if.slave bus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             core_hold
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] idx;
    logic [1:0]  byte_cnt;
    logic [23:0] word_lo;
    logic [7:0]  csum;

    logic        rx_ready_c;
    logic        accept;
    logic        restart;
    logic [15:0] n_full;
    logic        last_word;

    assign bus.rx_ready = rx_ready_c;
    assign accept       = bus.rx_valid && rx_ready_c;
    assign restart      = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign n_full       = {bus.rx_data, len_lo};
    assign last_word    = (idx == len - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rx_ready_c = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        core_hold  = 1'b1;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LEN0;
            end
            S_LEN0: begin
                rx_ready_c = 1'b1;
                busy       = 1'b1;
                if (accept) state_nxt = S_LEN1;
            end
            S_LEN1: begin
                rx_ready_c = 1'b1;
                busy       = 1'b1;
                if (accept) begin
                    if ({16'd0, n_full} > MAX_W) begin
                        state_nxt = S_ERR;
                    end else if (n_full == 16'd0) begin
                        state_nxt = S_CSUM;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                rx_ready_c = 1'b1;
                busy       = 1'b1;
                // Leave as soon as the last byte lands; its write issues while CSUM is already open.
                if (accept && byte_cnt == 2'd3 && last_word) state_nxt = S_CSUM;
            end
            S_CSUM: begin
                rx_ready_c = 1'b1;
                busy       = 1'b1;
                if (accept) state_nxt = (bus.rx_data == csum) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                done      = 1'b1;
                core_hold = 1'b0;
                if (start) state_nxt = S_LEN0;
            end
            S_ERR: begin
                err = 1'b1;
                if (start) state_nxt = S_LEN0;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.is_write <= 1'b0;
            bus.im_addr  <= BASE_ADDR;
            bus.im_inst  <= '0;
            len_lo       <= 8'd0;
            len          <= 16'd0;
            idx          <= 16'd0;
            byte_cnt     <= 2'd0;
            word_lo      <= 24'd0;
            csum         <= 8'd0;
        end else begin
            bus.is_write <= 1'b0;
            if (restart) begin
                idx      <= 16'd0;
                byte_cnt <= 2'd0;
                csum     <= 8'd0;
                len      <= 16'd0;
            end
            if (accept) begin
                case (state)
                    S_LEN0: len_lo <= bus.rx_data;
                    S_LEN1: len    <= n_full;
                    S_DATA: begin
                        csum     <= csum ^ bus.rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_lo[7:0]   <= bus.rx_data;
                            2'd1: word_lo[15:8]  <= bus.rx_data;
                            2'd2: word_lo[23:16] <= bus.rx_data;
                            default: begin
                                bus.is_write <= 1'b1;
                                bus.im_inst  <= W'({bus.rx_data, word_lo});
                                bus.im_addr  <= BASE_ADDR + (W'(idx) << 2);
                                idx          <= idx + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
